truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter SETTLE_CYCLES, default 1, SHALL set the cycles {a,b,c} are held before d_in is sampled; legal range 1..15.
REQ-003 Parameter EXPECTED[7:0], default 8'h15, SHALL be the golden truth table of d = (~a|~b)&~c, indexed by {a,b,c}.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a sweep; sampled on clk.
REQ-007 d_in  input  1  output of the boolean function under test; sampled on clk.
REQ-008 a, b, c  output  1 each  registered stimulus to the function under test; {a,b,c} = current vector index.
REQ-009 busy  output  1  high from the start acceptance edge until the done cycle.
REQ-010 done  output  1  one-cycle pulse at sweep completion.
REQ-011 table_out  output  8  captured truth table; bit i = d_in sampled for vector i.
REQ-012 pass  output  1  table_out == EXPECTED; valid from done and after it.
REQ-013 err_cnt  output  4  number of vectors where d_in != EXPECTED[idx], range 0..8.
REQ-014 first_fail  output  3  lowest failing vector index; 0 when err_cnt == 0.

Function
REQ-015 The FSM SHALL have the states IDLE, SETTLE, SAMPLE and FINISH.
REQ-016 IDLE: start=1 SHALL clear idx, the settle counter, table_out, err_cnt, first_fail and pass, and SHALL enter SETTLE with busy=1.
REQ-017 IDLE: start=0 SHALL keep the state and hold all result outputs.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles, counting from 0 to SETTLE_CYCLES-1, and then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and write table_out[idx] <= d_in.
REQ-020 SAMPLE: if d_in != EXPECTED[idx], it SHALL increment err_cnt, and SHALL load first_fail <= idx when err_cnt was 0.
REQ-021 SAMPLE with idx < 7 SHALL increment idx, clear the settle counter and go to SETTLE.
REQ-022 SAMPLE with idx == 7 SHALL go to FINISH; idx SHALL NOT wrap to 0 in the same cycle.
REQ-023 FINISH SHALL assert done for one cycle, register pass = (final table == EXPECTED), drop busy in the same cycle, return to IDLE and leave {a,b,c} at 3'b111.
REQ-024 {a,b,c} SHALL change only on the SAMPLE->SETTLE transition, or on start acceptance (to 3'b000); it SHALL be stable for SETTLE_CYCLES+1 cycles per vector.
REQ-025 start while in SETTLE, SAMPLE or FINISH SHALL be ignored: no restart and no queuing.
REQ-026 start held high SHALL launch a new sweep on the first IDLE cycle after done; back-to-back sweeps are therefore separated by one IDLE cycle.
REQ-027 Latency: done SHALL assert 8*(SETTLE_CYCLES+1)+1 cycles after the start acceptance edge (17 cycles at default).
REQ-028 err_cnt SHALL saturate only by construction, with maximum 8 and no overflow; err_cnt SHALL equal popcount(table_out ^ EXPECTED) at done.

Reset
REQ-029 rst_n low SHALL immediately force IDLE; idx=0, counter=0, a=b=c=0, busy=0, done=0, table_out=8'h00, pass=0, err_cnt=0, first_fail=0.
REQ-030 Reset asserted mid-sweep SHALL discard the partial results; the first start after release SHALL run a complete, correct sweep.
REQ-031 Reset release SHALL take effect on clk edges only; no start is accepted on the release edge unless rst_n is already high at that edge.

Verification
REQ-032 Model d_in=(~a|~b)&~c, default params, 1-cycle start -> done at +17 cycles; table_out=8'h15, pass=1, err_cnt=0, first_fail=0.
REQ-033 d_in tied 0 -> table_out=8'h00, pass=0, err_cnt=3, first_fail=0.
REQ-034 d_in=~c -> table_out=8'h55, pass=0, err_cnt=1, first_fail=6.
REQ-035 Start pulses during busy are ignored -> exactly one done; start held high -> done pulses 18 cycles apart.
REQ-036 rst_n low while idx=4 -> all outputs reach reset values asynchronously; the next sweep with the good model gives pass=1.
REQ-037 SETTLE_CYCLES=3 -> each vector held 4 cycles, done at +33 cycles, table_out=8'h15.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives all eight {a,b,c} vectors into a boolean function,
// captures its response and compares it to a golden table.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = 8'h15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       d_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    FINISH
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] settleCnt_q, settleCnt_d;
  logic [7:0] table_q, table_d;
  logic [3:0] errCnt_q, errCnt_d;
  logic [2:0] firstFail_q, firstFail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       clearEn;
  logic       settleEn;
  logic       sampleEn;
  logic       advanceEn;
  logic       finishEn;
  logic       mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETTLE;
      SETTLE:  if (settleCnt_q == SETTLE_LAST) state_d = SAMPLE;
      SAMPLE:  state_d = (idx_q == 3'd7) ? FINISH : SETTLE;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clearEn   = 1'b0;
    settleEn  = 1'b0;
    sampleEn  = 1'b0;
    advanceEn = 1'b0;
    finishEn  = 1'b0;
    case (state_q)
      IDLE:    clearEn  = start;
      SETTLE:  settleEn = 1'b1;
      SAMPLE: begin
        sampleEn  = 1'b1;
        advanceEn = (idx_q != 3'd7);
      end
      FINISH:  finishEn = 1'b1;
      default: ;
    endcase
  end

  // The last vector is not wrapped, so {a,b,c} rests at 3'b111 after a sweep.
  always_comb begin
    idx_d       = idx_q;
    settleCnt_d = settleCnt_q;
    table_d     = table_q;
    errCnt_d    = errCnt_q;
    firstFail_d = firstFail_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    mismatch    = (d_in != EXPECTED[idx_q]);

    if (clearEn) begin
      idx_d       = 3'd0;
      settleCnt_d = 4'd0;
      table_d     = 8'h00;
      errCnt_d    = 4'd0;
      firstFail_d = 3'd0;
      pass_d      = 1'b0;
      busy_d      = 1'b1;
    end

    if (settleEn && (settleCnt_q != SETTLE_LAST)) begin
      settleCnt_d = settleCnt_q + 4'd1;
    end

    if (sampleEn) begin
      table_d[idx_q] = d_in;
      if (mismatch) begin
        errCnt_d = errCnt_q + 4'd1;
        if (errCnt_q == 4'd0) begin
          firstFail_d = idx_q;
        end
      end
    end

    if (advanceEn) begin
      idx_d       = idx_q + 3'd1;
      settleCnt_d = 4'd0;
    end

    if (finishEn) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      pass_d = (table_q == EXPECTED);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= 3'd0;
      settleCnt_q <= 4'd0;
      table_q     <= 8'h00;
      errCnt_q    <= 4'd0;
      firstFail_q <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      settleCnt_q <= settleCnt_d;
      table_q     <= table_d;
      errCnt_q    <= errCnt_d;
      firstFail_q <= firstFail_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign a          = idx_q[2];
  assign b          = idx_q[1];
  assign c          = idx_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign table_out  = table_q;
  assign pass       = pass_q;
  assign err_cnt    = errCnt_q;
  assign first_fail = firstFail_q;

endmodule
